// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
//   size_e       : data access size encoding carried on data_mem_byte_en_i
//   init_state_e : memory-clear sequencer states
//   NOP_INSTR    : instruction returned whenever a fetch cannot be served
package mem_responder_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } size_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port.
//   lane_i      : byte address bits [1:0]
//   size_i      : access size
//   wr_data_i   : LSB-justified store data
//   rd_word_i   : full word currently held at the addressed index
//   misalign_o  : access is not naturally aligned (or size is reserved)
//   wr_mask_o   : per-byte write enables for the store
//   wr_lanes_o  : store data replicated into its destination lanes
//   rd_data_o   : selected bytes, LSB-justified and zero-extended
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_word_i,
  output logic        misalign_o,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] wr_lanes_o,
  output logic [31:0] rd_data_o
);

  // Store data is replicated across lanes; the mask picks which lanes land.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE     = 2'(gi);
    localparam int         HALF_OFS = (gi % 2) * 8;

    assign wr_mask_o[gi] = (size_i == BYTE) ? (lane_i == LANE) :
                           (size_i == HALF) ? (lane_i[1] == LANE[1]) :
                           (size_i == WORD);

    assign wr_lanes_o[gi*8 +: 8] = (size_i == BYTE) ? wr_data_i[7:0] :
                                   (size_i == HALF) ? wr_data_i[HALF_OFS +: 8] :
                                   wr_data_i[gi*8 +: 8];
  end

  always_comb begin
    misalign_o = 1'b0;
    rd_data_o  = '0;
    unique case (size_i)
      BYTE: rd_data_o = {24'h0, rd_word_i[{lane_i, 3'b000} +: 8]};
      HALF: begin
        misalign_o = lane_i[0];
        rd_data_o  = {16'h0, rd_word_i[{lane_i[1], 4'b0000} +: 16]};
      end
      WORD: begin
        misalign_o = (lane_i != 2'b00);
        rd_data_o  = rd_word_i;
      end
      RSVD: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory with combinational reads, masked stores,
// a power-up clear sequence and sticky error reporting.
//   clk, reset            : clock and synchronous active-high reset
//   instr_mem_*           : fetch request / byte address / instruction word
//   data_mem_*            : load/store request, address, size, direction, data
//   mem_ready_o           : clear sequence finished, stores accepted
//   misalign_err_o        : sticky, set by any misaligned request
//   range_err_o           : sticky, set by any request beyond the array
//   store_count_o         : committed stores, saturating
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_mem_req_i,
  input  logic [31:0] instr_mem_addr_i,
  output logic [31:0] instr_mem_rd_data_o,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        mem_ready_o,
  output logic        misalign_err_o,
  output logic        range_err_o,
  output logic [15:0] store_count_o
);

  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

  logic [31:0]          mem_q [DEPTH_WORDS];
  init_state_e          state_q;
  logic [ADDR_BITS-1:0] init_idx_q;
  logic                 ready_q;
  logic                 misalign_err_q;
  logic                 range_err_q;
  logic [15:0]          store_count_q;

  // Fetch path
  logic [ADDR_BITS-1:0] i_idx;
  logic                 i_misalign, i_range, i_ok;

  assign i_idx      = instr_mem_addr_i[ADDR_BITS+1:2];
  assign i_misalign = (instr_mem_addr_i[1:0] != 2'b00);
  assign i_range    = ((instr_mem_addr_i >> (ADDR_BITS + 2)) != 32'd0);
  assign i_ok       = instr_mem_req_i & ready_q & ~i_misalign & ~i_range;

  assign instr_mem_rd_data_o = i_ok ? mem_q[i_idx] : NOP_INSTR;

  // Data path
  logic [ADDR_BITS-1:0] d_idx;
  logic                 d_misalign, d_range, d_ok;
  logic [3:0]           d_mask;
  logic [31:0]          d_lanes, d_rd_aligned;
  logic                 store_commit_d;

  assign d_idx   = data_mem_addr_i[ADDR_BITS+1:2];
  assign d_range = ((data_mem_addr_i >> (ADDR_BITS + 2)) != 32'd0);

  mem_lane_align u_align (
    .lane_i     (data_mem_addr_i[1:0]),
    .size_i     (size_e'(data_mem_byte_en_i)),
    .wr_data_i  (data_mem_wr_data_i),
    .rd_word_i  (mem_q[d_idx]),
    .misalign_o (d_misalign),
    .wr_mask_o  (d_mask),
    .wr_lanes_o (d_lanes),
    .rd_data_o  (d_rd_aligned)
  );

  assign d_ok               = data_mem_req_i & ready_q & ~d_misalign & ~d_range;
  assign data_mem_rd_data_o = d_ok ? d_rd_aligned : 32'h0;
  // Reset takes priority so a store coinciding with reset never lands.
  assign store_commit_d     = d_ok & data_mem_wr_i & ~reset;

  // Single write port: clearing owns it during INIT, stores afterwards.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[init_idx_q] <= '0;
    end else if (store_commit_d) begin
      for (int b = 0; b < 4; b++) begin
        if (d_mask[b]) mem_q[d_idx][b*8 +: 8] <= d_lanes[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= INIT;
      init_idx_q     <= '0;
      ready_q        <= 1'b0;
      misalign_err_q <= 1'b0;
      range_err_q    <= 1'b0;
      store_count_q  <= '0;
    end else begin
      if (state_q == INIT) begin
        init_idx_q <= init_idx_q + 1'b1;
        if (&init_idx_q) begin
          state_q <= READY;
          ready_q <= 1'b1;
        end
      end
      misalign_err_q <= misalign_err_q | (data_mem_req_i & d_misalign)
                                       | (instr_mem_req_i & i_misalign);
      range_err_q    <= range_err_q | (data_mem_req_i & d_range)
                                    | (instr_mem_req_i & i_range);
      if (store_commit_d && (store_count_q != 16'hFFFF)) begin
        store_count_q <= store_count_q + 16'd1;
      end
    end
  end

  assign mem_ready_o    = ready_q;
  assign misalign_err_o = misalign_err_q;
  assign range_err_o    = range_err_q;
  assign store_count_o  = store_count_q;

endmodule
